// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: priority redirects (trap > branch > jal > jalr),
// sequential advance on accepted fetch. Optional target alignment check: PC_ALIGN_CHK_EN.
module pc_gen #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] pc_b_i,
  input  logic            jump_jal_i,
  input  logic [XLEN-1:0] pc_jal_i,
  input  logic            jump_jalr_i,
  input  logic [XLEN-1:0] pc_jalr_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] mis_addr_o
);

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt;
  logic            req;
  logic            take;
  logic            fire;

  always_comb begin
    req = trap_i | branch_i | jump_jal_i | jump_jalr_i;
    tgt = '0;
    if (trap_i)           tgt = trap_vec_i;
    else if (branch_i)    tgt = pc_b_i;
    else if (jump_jal_i)  tgt = pc_jal_i;
    else if (jump_jalr_i) tgt = pc_jalr_i & ~XLEN'(1);
  end

`ifdef PC_ALIGN_CHK_EN
  logic            misalign_q;
  logic [XLEN-1:0] mis_addr_q;
  logic            bad_tgt;

  assign bad_tgt = |tgt[1:0];
  assign take    = req & ~bad_tgt;

  // A rejected redirect still owns the cycle (flush, no increment); it only records the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      misalign_q <= req & bad_tgt;
      if (req & bad_tgt) mis_addr_q <= tgt;
    end
  end

  assign misalign_o = misalign_q;
  assign mis_addr_o = mis_addr_q;
`else
  assign take       = req;
  assign misalign_o = 1'b0;
  assign mis_addr_o = '0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_o = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        state_d       = RUN;
        fetch_valid_o = ~stall_i;
      end
      default: state_d = BOOT;
    endcase
    fire = fetch_valid_o & fetch_ready_i;
    if (req) begin
      if (take) pc_d = tgt;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_pc_o = pc_q;
  assign flush_o    = req;

endmodule
